// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multicycle multiply/divide sequencer.
//   - operation encodings carried on the Op port
//   - controller state encoding
//   - default operand width and the matching iteration counter width
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER_W    = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_MLA = 2'b01,
        OP_DIV = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the execute stage and the
// multicycle multiply/divide sequencer.
//   master (execute stage): drives Start, Op, Unsigned, a, b, c;
//                           receives Busy, Done, Result, Result2, DivByZero.
//   slave  (muldiv_seq)   : the mirror image.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic             Unsigned;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result2;
    logic             DivByZero;

    modport master (
        output Start, Op, Unsigned, a, b, c,
        input  Busy, Done, Result, Result2, DivByZero
    );

    modport slave (
        input  Start, Op, Unsigned, a, b, c,
        output Busy, Done, Result, Result2, DivByZero
    );
endinterface

// File: rtl/muldiv_dp.sv
// muldiv_dp: one-bit-per-cycle shift-add multiplier / restoring divider.
//   clk, reset      : clock, asynchronous active-high reset
//   ld              : load operand magnitudes and clear the upper word
//   step            : perform one iteration
//   is_div          : 1 = restoring divide step, 0 = shift-add multiply step
//   mag_a, mag_b    : unsigned operand magnitudes
//   hi, lo          : multiply -> product {hi,lo}; divide -> remainder hi, quotient lo
module muldiv_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // hi: accumulator upper half (MUL) or partial remainder (DIV)
    // lo: multiplier shifting out / product low half (MUL), dividend shifting
    //     out / quotient shifting in (DIV)
    // m : the fixed operand added or subtracted each step
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q,  m_d;

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;
    logic           rem_ge;

    always_comb begin
        add_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : '0)};
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, m_q});
        rem_diff  = rem_shift - {1'b0, m_q};

        hi_d = hi_q;
        lo_d = lo_q;
        m_d  = m_q;
        if (ld) begin
            hi_d = '0;
            lo_d = is_div ? mag_a : mag_b;
            m_d  = is_div ? mag_b : mag_a;
        end else if (step) begin
            if (is_div) begin
                // With a zero divisor every compare succeeds, so the quotient
                // fills with ones; the controller overrides that result.
                hi_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], rem_ge};
            end else begin
                // The carry out of the add becomes the top bit after the shift.
                hi_d = add_sum[WIDTH:1];
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            m_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            m_q  <= m_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multicycle sequencer for MUL/UMULL/SMULL, MLA/UMLAL/SMLAL and
// UDIV/SDIV. Fixed latency of WIDTH+3 cycles from the Start cycle to Done.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : muldiv_seq_if slave -- Start/Op/Unsigned/a/b/c in,
//           Busy/Done/Result/Result2/DivByZero out
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);

    state_e            state_q;
    logic [ITER_W-1:0] cnt_q;
    op_e               op_q;
    logic              uns_q;
    logic [WIDTH-1:0]  a_q, b_q, c_q;
    logic              neg_res_q, neg_rem_q;
    logic              busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]  result_q, result2_q;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   dp_hi, dp_lo;
    logic [2*WIDTH-1:0] prod, c_ext;
    logic [WIDTH-1:0]   fix_lo, fix_hi;

    // Two's-complement magnitude; unsigned operands pass through.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_uns);
        return (!is_uns && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    assign mag_a = magnitude(a_q, uns_q);
    assign mag_b = magnitude(b_q, uns_q);

    muldiv_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .ld     (state_q == ST_PREP),
        .step   (state_q == ST_ITER),
        .is_div (op_q == OP_DIV),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .hi     (dp_hi),
        .lo     (dp_lo)
    );

    // Sign restoration and accumulate, evaluated while in FIX.
    always_comb begin
        prod = {dp_hi, dp_lo};
        if (neg_res_q) prod = ~prod + 1'b1;
        c_ext = {{WIDTH{~uns_q & c_q[WIDTH-1]}}, c_q};
        if (op_q == OP_MLA) prod = prod + c_ext;
        fix_lo = prod[WIDTH-1:0];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        if (op_q == OP_DIV) begin
            if (dbz_q) begin
                // Zero quotient, dividend returned as remainder.
                fix_lo = '0;
                fix_hi = a_q;
            end else begin
                fix_lo = neg_res_q ? (~dp_lo + 1'b1) : dp_lo;
                fix_hi = neg_rem_q ? (~dp_hi + 1'b1) : dp_hi;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            uns_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            result_q  <= '0;
            result2_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Start) begin
                        op_q    <= op_e'(bus.Op);
                        uns_q   <= bus.Unsigned;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        c_q     <= bus.c;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    neg_res_q <= ~uns_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem_q <= ~uns_q & a_q[WIDTH-1];
                    dbz_q     <= (op_q == OP_DIV) && (b_q == '0);
                    cnt_q     <= '0;
                    state_q   <= ST_ITER;
                end
                ST_ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ITER_W'(WIDTH - 1)) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    result_q  <= fix_lo;
                    result2_q <= fix_hi;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Result    = result_q;
    assign bus.Result2   = result2_q;
    assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from IDLE (called 1 time unit after a rising edge).
    // Returns the Done cycle number (Start cycle = 0, -1 on timeout), the
    // outputs seen in the Done cycle, and whether Busy behaved along the way.
    // Leaves the bench 1 time unit after the edge following Done.
    task automatic run_op(input logic [1:0] op, input logic uns,
                          input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ic,
                          output int lat, output logic [W-1:0] res,
                          output logic [W-1:0] res2, output logic dbz,
                          output logic busy_ok);
        bus.Op = op; bus.Unsigned = uns;
        bus.a = ia; bus.b = ib; bus.c = ic;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.Op = 2'b00;
        lat = -1; busy_ok = 1'b1;
        res = '0; res2 = '0; dbz = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.Done) begin
                lat = k;
                if (bus.Busy) busy_ok = 1'b0;
                res = bus.Result; res2 = bus.Result2; dbz = bus.DivByZero;
                break;
            end
            if (!bus.Busy) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.Busy, bus.Done, bus.DivByZero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000", {bus.Busy, bus.Done, bus.DivByZero});
        end
        checks++;
        if ({bus.Result2, bus.Result} !== 64'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", {bus.Result2, bus.Result});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_unsigned();
        int lat; logic [W-1:0] r, r2; logic dz, bok;
        run_op(2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, lat, r, r2, dz, bok);
        checks++;
        if ({r2, r} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL umul: got %h expected fffffffe00000001", {r2, r});
        end
        checks++;
        if (lat !== 35) begin
            errors++; $display("FAIL umul_latency: got %0d expected 35", lat);
        end
        checks++;
        if (bok !== 1'b1) begin
            errors++; $display("FAIL umul_busy: got %b expected 1", bok);
        end
    endtask

    task automatic test_signed_mul_mla();
        int lat; logic [W-1:0] r, r2; logic dz, bok;
        run_op(2'b00, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h0, lat, r, r2, dz, bok);
        checks++;
        if ({r2, r} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++; $display("FAIL smul: got %h expected ffffffffffffffeb", {r2, r});
        end
        run_op(2'b01, 1'b0, 32'hFFFF_FFFE, 32'd5, 32'd100, lat, r, r2, dz, bok);
        checks++;
        if ({r2, r} !== 64'h0000_0000_0000_005A) begin
            errors++; $display("FAIL smla: got %h expected 000000000000005a", {r2, r});
        end
        // Reserved op code behaves as MUL (accumulator ignored): 9*11 = 99.
        run_op(2'b11, 1'b1, 32'd9, 32'd11, 32'd1000, lat, r, r2, dz, bok);
        checks++;
        if ({r2, r} !== 64'd99) begin
            errors++; $display("FAIL rsv_as_mul: got %h expected 63", {r2, r});
        end
    endtask

    task automatic test_div_signs();
        int lat; logic [W-1:0] r, r2; logic dz, bok;
        run_op(2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h0, lat, r, r2, dz, bok);
        checks++;
        if ({r, r2} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL sdiv: got q=%h r=%h expected q=fffffffd r=ffffffff", r, r2);
        end
        run_op(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h0, lat, r, r2, dz, bok);
        checks++;
        if ({r, r2} !== {32'h7FFF_FFFC, 32'h0000_0001}) begin
            errors++; $display("FAIL udiv: got q=%h r=%h expected q=7ffffffc r=00000001", r, r2);
        end
    endtask

    task automatic test_div_boundary();
        int lat; logic [W-1:0] r, r2; logic dz, bok;
        run_op(2'b10, 1'b1, 32'd5, 32'd0, 32'h0, lat, r, r2, dz, bok);
        checks++;
        if ({r, r2, dz} !== {32'd0, 32'd5, 1'b1}) begin
            errors++; $display("FAIL div0: got q=%h r=%h dbz=%b expected q=0 r=5 dbz=1", r, r2, dz);
        end
        checks++;
        if (lat !== 35) begin
            errors++; $display("FAIL div0_latency: got %0d expected 35", lat);
        end
        // Outputs and the flag hold through IDLE.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.Result, bus.Result2, bus.DivByZero, bus.Done} !== {32'd0, 32'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold: got q=%h r=%h dbz=%b done=%b expected q=0 r=5 dbz=1 done=0",
                     bus.Result, bus.Result2, bus.DivByZero, bus.Done);
        end
        run_op(2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, lat, r, r2, dz, bok);
        checks++;
        if ({r, r2, dz} !== {32'h8000_0000, 32'd0, 1'b0}) begin
            errors++; $display("FAIL div_ovf: got q=%h r=%h dbz=%b expected q=80000000 r=0 dbz=0", r, r2, dz);
        end
    endtask

    task automatic test_start_ignored();
        int first_done; int ndone;
        bus.Op = 2'b00; bus.Unsigned = 1'b1;
        bus.a = 32'd3; bus.b = 32'd5; bus.c = 32'd0;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        first_done = -1; ndone = 0;
        for (int k = 1; k <= 80; k++) begin
            // Cycle 12 is ITER count 10: a stray request with other operands.
            if (k == 12) begin
                bus.a = 32'd100; bus.b = 32'd100; bus.Start = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ndone !== 1 || first_done !== 35) begin
            errors++; $display("FAIL start_ignored: got %0d done(s), first at %0d expected 1 at 35", ndone, first_done);
        end
        checks++;
        if (bus.Result !== 32'd15) begin
            errors++; $display("FAIL start_ignored_result: got %0d expected 15", bus.Result);
        end
    endtask

    task automatic test_back_to_back();
        int d1; int d2; logic [W-1:0] q1, r1, q2, r2;
        bus.Op = 2'b10; bus.Unsigned = 1'b1;
        bus.a = 32'd100; bus.b = 32'd7; bus.c = 32'd0;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        d1 = -1; d2 = -1;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int k = 1; k <= 90; k++) begin
            if (bus.Done) begin
                if (d1 < 0) begin
                    d1 = k; q1 = bus.Result; r1 = bus.Result2;
                end else begin
                    d2 = k; q2 = bus.Result; r2 = bus.Result2;
                    bus.Start = 1'b0;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        bus.Start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (d1 !== 35 || d2 !== 71) begin
            errors++; $display("FAIL b2b_timing: got done at %0d,%0d expected 35,71", d1, d2);
        end
        checks++;
        if ({q1, r1, q2, r2} !== {32'd14, 32'd2, 32'd14, 32'd2}) begin
            errors++; $display("FAIL b2b_result: got %0d r%0d, %0d r%0d expected 14 r2 twice", q1, r1, q2, r2);
        end
        // Nothing further runs once Start drops.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: busy %b expected 0", bus.Busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; int ndone; logic [W-1:0] r, r2; logic dz, bok;
        bus.Op = 2'b00; bus.Unsigned = 1'b1;
        bus.a = 32'h1234; bus.b = 32'h10; bus.c = 32'd0;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.Busy, bus.Done, bus.DivByZero, bus.Result, bus.Result2} !== 67'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b dbz=%b q=%h r=%h expected all 0",
                     bus.Busy, bus.Done, bus.DivByZero, bus.Result, bus.Result2);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 50; k++) begin
            if (bus.Done || bus.Busy) ndone++;
            @(posedge clk); #1;
        end
        checks++;
        if (ndone !== 0) begin
            errors++; $display("FAIL reset_discard: got %0d active cycles expected 0", ndone);
        end
        run_op(2'b00, 1'b1, 32'd6, 32'd7, 32'd0, lat, r, r2, dz, bok);
        checks++;
        if ({r2, r} !== 64'd42 || lat !== 35) begin
            errors++; $display("FAIL post_reset_mul: got %0d at %0d expected 42 at 35", r, lat);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.Unsigned = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0;
        reset = 1'b0;
        #1;
        test_reset();
        test_mul_unsigned();
        test_signed_mul_mla();
        test_div_signs();
        test_div_boundary();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multicycle sequencer for the core's long-latency integer operations: MUL/UMULL/SMULL, MLA/UMLAL/SMLAL and UDIV/SDIV. It runs these over 32 iterations of a shift-add / restoring-divide datapath, so the single-cycle ALU no longer carries combinational `*` and `/`. It sits beside the ALU in the execute stage. The controller holds `Busy` to stall fetch/decode and pulses `Done` when `Result`/`Result2` are ready for writeback.

## Interface
- `WIDTH`, 32, operand width; iteration count = `WIDTH`; fixed latency = `WIDTH`+3.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  request; sampled only in IDLE.
- `Op`  in  2  00 MUL, 01 MLA, 10 DIV, 11 reserved (treated as MUL).
- `Unsigned`  in  1  1 = unsigned, 0 = two's-complement.
- `a`, `b`  in  WIDTH  multiplicand/multiplier or dividend/divisor.
- `c`  in  WIDTH  MLA accumulator addend.
- `Busy`  out  1  high in PREP/ITER/FIX.
- `Done`  out  1  one-cycle pulse in DONE.
- `Result`  out  WIDTH  low product word or quotient.
- `Result2`  out  WIDTH  high product word or remainder.
- `DivByZero`  out  1  DIV with `b`==0; valid with `Done`, held afterwards.

## Operation
- FSM states: IDLE → PREP → ITER (×`WIDTH`) → FIX → DONE → IDLE.
- **IDLE, `Start`=1:** latch `Op`, `Unsigned`, `a`, `b`, `c`. Inputs are don't-care after this edge.
- **PREP:**
  - Form magnitudes `|a|`, `|b|` (negate if signed and MSB set).
  - Record `neg_res` = `a[31]^b[31]` and `neg_rem` = `a[31]` (both 0 when unsigned).
  - Clear the 64-bit accumulator and the counter.
  - Set `DivByZero` = (Op==DIV && `b`==0).
- **ITER, MUL/MLA:** if multiplier LSB is set, add `|a|` into the upper half; shift {acc, multiplier} right by 1.
- **ITER, DIV:** shift {rem, quo} left by 1; if rem ≥ `|b|`, subtract and set quotient bit. Counter 0..`WIDTH`-1; leave on count=`WIDTH`-1.
- **FIX:**
  - Apply two's-complement negation to the 64-bit product if `neg_res`.
  - MLA adds `c`, zero-extended (unsigned) or sign-extended (signed), mod 2^64.
  - DIV: negate the quotient if `neg_res`; negate the remainder if `neg_rem`.
  - Load `Result`/`Result2`.
- **DONE:** `Done`=1 for one cycle, then return to IDLE.
- **Divide by zero:** runs the full latency. The quotient datapath yields all-ones; FIX overrides to `Result`=0, `Result2`=`a` (ARM-style zero quotient).
- **Signed 0x80000000 / 0xFFFFFFFF:** `Result`=0x80000000, `Result2`=0. This is a natural wrap; no flag.
- **Output hold:** outputs hold their value from FIX until the next FIX; they do not change in IDLE.

## Timing
- `Start` sampled at edge E0.
  - PREP after E0.
  - ITER after E1.
  - FIX after E(`WIDTH`+1).
  - DONE after E(`WIDTH`+2).
- `Done` is high in cycle `WIDTH`+3 after the `Start` cycle (35 for `WIDTH`=32). The latency is independent of operands.
- `Busy` rises the cycle after `Start` is accepted and falls as `Done` rises. `Busy` and `Done` are never high together.
- `Start` during PREP/ITER/FIX/DONE is ignored, not queued. The earliest back-to-back `Start` is in the cycle after `Done`.
- **Reset:** asynchronous, any state. The FSM goes to IDLE; `Busy`, `Done`, `DivByZero`, `Result`, `Result2`, the counter and internal registers all go to 0. An in-flight op is discarded with no `Done`.

## Structure
- `muldiv_pkg`:
  - op encodings `OP_MUL`, `OP_MLA`, `OP_DIV`;
  - state enum IDLE/PREP/ITER/FIX/DONE;
  - constant `ITER_W` = $clog2(`WIDTH`).
- One sub-module, `muldiv_dp`: the accumulator/remainder and shift registers plus the add/subtract-compare.
  - Control inputs: `ld`, `step`, `is_div`.
  - The FSM, counter, sign bookkeeping and FIX stage stay in `muldiv_seq`.

## Test plan
- **Unsigned MUL:** `a`=`b`=0xFFFFFFFF → `Result2`=0xFFFFFFFE, `Result`=0x00000001, `Done` exactly 35 cycles after `Start`.
- **Signed MUL and MLA:**
  - MUL, `a`=-3, `b`=7 → `Result2`=0xFFFFFFFF, `Result`=0xFFFFFFEB.
  - MLA signed, `c`=100, `a`=-2, `b`=5 → `Result2`=0, `Result`=0x0000005A.
- **Signed DIV, sign rules:** `a`=-7, `b`=2 → `Result`=0xFFFFFFFD, `Result2`=0xFFFFFFFF.
  - Unsigned, `a`=0xFFFFFFF9, `b`=2 → `Result`=0x7FFFFFFC, `Result2`=1.
- **DIV boundary cases:**
  - `a`=5, `b`=0 → `Result`=0, `Result2`=5, `DivByZero`=1, still 35 cycles.
  - Signed 0x80000000 / 0xFFFFFFFF → `Result`=0x80000000, `Result2`=0, `DivByZero`=0.
- **Handshake:** `Start` pulsed at ITER count 10 → ignored, single `Done`. `Start` held high continuously → ops complete every 36 cycles.
- **Reset mid-op:** `reset` asserted at ITER count 10 → all outputs 0 immediately, no `Done`. A following `Start` with MUL 6×7 → `Result`=42 after 35 cycles.
